// File: rtl/switch_debounce_port.sv
// ---------------------------------------------------------------------------
// switch_debounce_port
//   MMIO read port for N_SW board switches. Each channel runs through a
//   2-flop synchroniser, a counter-based debouncer and a sticky change flag.
//   Two CPU-visible words are provided: the debounced switch value (DATA) and
//   the read-to-clear change flags (CHG). irq_o is high while any change flag
//   is set.
//
// Ports
//   clk_i    in   1      system clock
//   rst_ni   in   1      asynchronous reset, active low
//   addr     in   12     peripheral offset address
//   rd_en_i  in   1      bus read strobe; only qualifies the CHG clear
//   data_sw  in   N_SW   raw asynchronous switch levels
//   rdata    out  32     registered read data (1-cycle latency)
//   irq_o    out  1      OR of all change flags
// ---------------------------------------------------------------------------
module switch_debounce_port #(
    parameter int unsigned N_SW      = 24,
    parameter int unsigned DB_CYCLES = 20000,
    parameter bit          SIGN_EXT  = 1'b1,
    parameter logic [11:0] ADDR_DATA = 12'h070,
    parameter logic [11:0] ADDR_CHG  = 12'h074
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [11:0]     addr,
    input  logic            rd_en_i,
    input  logic [N_SW-1:0] data_sw,
    output logic [31:0]     rdata,
    output logic            irq_o
);

    localparam int unsigned      CNT_W    = $clog2(DB_CYCLES + 1);
    // Terminal count: the mismatch must persist through DB_CYCLES samples,
    // and the last of them is the one that performs the acceptance.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_SW-1:0]  sync1_q;
    logic [N_SW-1:0]  sync2_q;
    logic [N_SW-1:0]  stable_q;
    logic [N_SW-1:0]  stable_d;
    logic [N_SW-1:0]  chg_q;
    logic [N_SW-1:0]  chg_d;
    logic [N_SW-1:0]  accept;
    logic [CNT_W-1:0] cnt_q [N_SW];
    logic [CNT_W-1:0] cnt_d [N_SW];
    logic [31:0]      data_word;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             chg_clr;

    // -----------------------------------------------------------------------
    // Debounce: count consecutive cycles where the synchronised level differs
    // from the accepted level; any return to the accepted level restarts.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        accept = '0;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // An accepted channel always flips, since it only counts while it differs.
    assign stable_d = stable_q ^ accept;

    // Set wins over the read-clear so an acceptance landing on the clearing
    // read is never lost.
    assign chg_clr = rd_en_i && (addr == ADDR_CHG);
    assign chg_d   = (chg_clr ? '0 : chg_q) | accept;

    // -----------------------------------------------------------------------
    // Read mux. At N_SW == 32 both extensions collapse to the raw value.
    // -----------------------------------------------------------------------
    always_comb begin
        if (SIGN_EXT) begin
            data_word = 32'(signed'(stable_q));
        end else begin
            data_word = 32'(stable_q);
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (addr == ADDR_DATA) begin
            rdata_d = data_word;
        end else if (addr == ADDR_CHG) begin
            // Pre-clear flags are returned; the clear lands on the same edge.
            rdata_d = 32'(chg_q);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            chg_q    <= '0;
            rdata_q  <= '0;
            // NOTE: the counter array is ordinary flops (not a RAM), so it is
            // reset with the rest; a reset mid-debounce must discard counts.
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep the synchroniser a true
            // two-stage shift; blocking here would collapse it to one flop.
            sync1_q  <= data_sw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            chg_q    <= chg_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rdata = rdata_q;
    assign irq_o = |chg_q;

endmodule
